// File: rtl/jk_pkg.sv
// Shared opcodes, sequencer state encoding and the JK next-state rule used by
// the command sequencer that drives a downstream jk_ff.
package jk_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StDrive
    } seq_state_e;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic q_n;
        unique case (jk)
            OP_HOLD: q_n = q;
            OP_CLR:  q_n = 1'b0;
            OP_SET:  q_n = 1'b1;
            OP_TGL:  q_n = ~q;
            default: q_n = q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout_o without a pop.
// A full FIFO refuses a push even when a pop happens in the same cycle.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o  = (cnt_q == (AW+1)'(DEPTH));
        empty_o = (cnt_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        dout_o  = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; contents are only read once the count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer: replays buffered {op,count} commands as j/k held for count+1
// cycles with no bubbles, and flags any divergence of the fed-back q from a local model.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             q_fb,
    input  logic             check_en,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned W = 2 + CNT_W;

    seq_state_e       state_q;
    logic [CNT_W-1:0] rem_q;
    logic             j_q;
    logic             k_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             q_pred_q;

    logic [W-1:0]     fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .din_i   ({cmd_op, cmd_count}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        cmd_ready = !fifo_full;
        head_op   = fifo_dout[W-1 -: 2];
        head_cnt  = fifo_dout[CNT_W-1:0];
        // Pop when idle, or on the last drive cycle so the next command follows with no gap.
        pop       = !fifo_empty && ((state_q == StIdle) || (rem_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            q_pred_q <= 1'b0;
        end else begin
            q_pred_q <= jk_next(q_pred_q, {j_q, k_q});
            err_q    <= err_q | (check_en && (q_fb != q_pred_q));
            if (pop) begin
                state_q      <= StDrive;
                {j_q, k_q}   <= head_op;
                rem_q        <= head_cnt;
                busy_q       <= 1'b1;
                done_q       <= (head_cnt == '0);
            end else if ((state_q == StDrive) && (rem_q != '0)) begin
                rem_q  <= rem_q - CNT_W'(1);
                done_q <= (rem_q == CNT_W'(1));
            end else begin
                state_q <= StIdle;
                j_q     <= 1'b0;
                k_q     <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        j    = j_q;
        k    = k_q;
        busy = busy_q;
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq driving a behavioural jk_ff whose q is fed back to q_fb.
module tb_jk_cmd_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             q_fb;
    logic             check_en;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             err;
    logic             q_ff;
    logic             force_en;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [1:0] op;
        logic       last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Downstream jk_ff
    always @(posedge clk) begin
        if (reset) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q_fb = force_en ? 1'b0 : q_ff;

    jk_cmd_seq #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .q_fb      (q_fb),
        .check_en  (check_en),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // One clock; accepted commands expand into per-cycle expectations, drive cycles pop them.
    task automatic tick();
        logic             acc;
        logic             rst_s;
        logic [1:0]       op_s;
        logic [CNT_W-1:0] c_s;
        exp_t             e;
        acc   = cmd_valid && cmd_ready && !reset;
        rst_s = reset;
        op_s  = cmd_op;
        c_s   = cmd_count;
        @(posedge clk);
        #1;
        if (rst_s) exp_q.delete();
        else if (acc) begin
            for (int i = 0; i <= int'(c_s); i++) begin
                e.op   = op_s;
                e.last = (i == int'(c_s));
                exp_q.push_back(e);
            end
        end
        n_chk++;
        if (busy) begin
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: busy with jk=%b done=%b, required no drive", {j, k}, done);
            end else begin
                e = exp_q.pop_front();
                if ({j, k} !== e.op || done !== e.last)
                    $display("FAIL sb_drive: jk=%b done=%b, required jk=%b done=%b",
                             {j, k}, done, e.op, e.last);
                else n_pass++;
            end
        end else begin
            if ({j, k, done} !== 3'b000)
                $display("FAIL sb_idle: jk=%b done=%b, required 00/0", {j, k}, done);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({j, k, busy, done, err} !== 5'b00000)
            $display("FAIL reset_outputs: jkbde=%b, required 00000", {j, k, busy, done, err});
        else n_pass++;
        n_chk++;
        if (cmd_ready !== 1'b1)
            $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int nj = 0;
        int nd = 0;
        int done_at = -1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_count = 4'd2;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (j && !k) nj++;
            if (done) begin
                nd++;
                done_at = nj;
            end
        end
        n_chk++;
        if (nj !== 3) $display("FAIL single_len: set cycles=%0d, required 3", nj);
        else n_pass++;
        n_chk++;
        if (nd !== 1 || done_at !== 3)
            $display("FAIL single_done: pulses=%0d at=%0d, required 1 at 3", nd, done_at);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL single_idle: busy=%b pending=%0d, required 0/0", busy, exp_q.size());
        else n_pass++;
        n_chk++;
        if (q_ff !== 1'b1 || err !== 1'b0)
            $display("FAIL single_q: q=%b err=%b, required q=1 err=0", q_ff, err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]       ops[3]     = '{2'b01, 2'b11, 2'b00};
        logic [CNT_W-1:0] cnts[3]    = '{4'd0, 4'd3, 4'd1};
        logic [1:0]       exp_seq[7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [1:0]       seq[$];
        int nd = 0;
        int first_t = -1;
        int last_t = -1;
        for (int t = 0; t < 13; t++) begin
            if (t < 3) begin
                cmd_valid = 1'b1;
                cmd_op    = ops[t];
                cmd_count = cnts[t];
            end else cmd_valid = 1'b0;
            tick();
            if (busy) begin
                seq.push_back({j, k});
                if (first_t < 0) first_t = t;
                last_t = t;
            end
            if (done) nd++;
        end
        n_chk++;
        if (seq.size() != 7 || (last_t - first_t + 1) != 7)
            $display("FAIL b2b_len: busy cycles=%0d span=%0d, required 7/7",
                     seq.size(), last_t - first_t + 1);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (i >= seq.size() || seq[i] !== exp_seq[i])
                $display("FAIL b2b_seq[%0d]: jk=%b, required %b", i,
                         (i < seq.size()) ? seq[i] : 2'bxx, exp_seq[i]);
            else n_pass++;
        end
        n_chk++;
        if (nd !== 3) $display("FAIL b2b_done: pulses=%0d, required 3", nd);
        else n_pass++;
        n_chk++;
        if (q_ff !== 1'b0 || err !== 1'b0)
            $display("FAIL b2b_q: q=%b err=%b, required q=0 err=0", q_ff, err);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [1:0] ops[6] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
        int  idx = 0;
        int  n_acc = 0;
        bit  seen = 1'b0;
        bit  chk_next = 1'b0;
        bit  acc;
        for (int t = 0; t < 200 && !(idx == 6 && !busy && exp_q.size() == 0); t++) begin
            if (idx < 6) begin
                cmd_valid = 1'b1;
                cmd_op    = ops[idx];
                cmd_count = 4'd15;
            end else cmd_valid = 1'b0;
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                n_acc++;
                idx++;
            end
            if (chk_next) begin
                chk_next = 1'b0;
                n_chk++;
                if (cmd_ready !== 1'b1)
                    $display("FAIL full_ready_rise: cmd_ready=%b, required 1", cmd_ready);
                else n_pass++;
            end
            if (done && !seen) begin
                seen     = 1'b1;
                chk_next = 1'b1;
                n_chk++;
                if (n_acc !== DEPTH + 1)
                    $display("FAIL full_accepted: %0d, required %0d", n_acc, DEPTH + 1);
                else n_pass++;
                n_chk++;
                if (cmd_ready !== 1'b0)
                    $display("FAIL full_ready_low: cmd_ready=%b, required 0", cmd_ready);
                else n_pass++;
            end
        end
        cmd_valid = 1'b0;
        n_chk++;
        if (idx !== 6 || busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL full_drain: accepted=%0d busy=%b pending=%0d, required 6/0/0",
                     idx, busy, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_err();
        n_chk++;
        if (err !== 1'b0) $display("FAIL err_pre: err=%b, required 0", err);
        else n_pass++;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_count = 4'd5;
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 10 && !(busy && q_ff); t++) tick();
        n_chk++;
        if (busy !== 1'b1 || q_ff !== 1'b1 || err !== 1'b0)
            $display("FAIL err_setup: busy=%b q=%b err=%b, required 1/1/0", busy, q_ff, err);
        else n_pass++;
        force_en = 1'b1;
        tick();
        force_en = 1'b0;
        n_chk++;
        if (err !== 1'b1) $display("FAIL err_set: err=%b, required 1", err);
        else n_pass++;
        tick();
        n_chk++;
        if (err !== 1'b1) $display("FAIL err_hold: err=%b, required 1", err);
        else n_pass++;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_count = 4'd1;
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 40 && (busy || exp_q.size() != 0); t++) tick();
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_sticky: err=%b busy=%b, required 1/0", err, busy);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [1:0]       ops[3]  = '{2'b11, 2'b01, 2'b10};
        logic [CNT_W-1:0] cnts[3] = '{4'd10, 4'd2, 4'd3};
        int act = 0;
        for (int t = 0; t < 5; t++) begin
            if (t < 3) begin
                cmd_valid = 1'b1;
                cmd_op    = ops[t];
                cmd_count = cnts[t];
            end else cmd_valid = 1'b0;
            tick();
        end
        n_chk++;
        if (busy !== 1'b1 || {j, k} !== 2'b11)
            $display("FAIL abort_pre: busy=%b jk=%b, required 1/11", busy, {j, k});
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if ({j, k, busy, done, err} !== 5'b00000)
            $display("FAIL abort_outputs: jkbde=%b, required 00000", {j, k, busy, done, err});
        else n_pass++;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL abort_ready: cmd_ready=%b, required 1", cmd_ready);
        else n_pass++;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (busy || done) act++;
        end
        n_chk++;
        if (act !== 0) $display("FAIL abort_flushed: active cycles=%0d, required 0", act);
        else n_pass++;
        n_chk++;
        if (err !== 1'b0) $display("FAIL abort_qpred: err=%b, required 0", err);
        else n_pass++;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_count = 4'd1;
        tick();
        cmd_valid = 1'b0;
        for (int t = 0; t < 20 && (busy || exp_q.size() != 0); t++) tick();
        n_chk++;
        if (q_ff !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL abort_resume: q=%b err=%b busy=%b pending=%0d, required 1/0/0/0",
                     q_ff, err, busy, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        check_en  = 1'b1;
        force_en  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_err();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
